// File: rtl/video_pkg.sv
// Shared video types and colour constants for the layered colour mapper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package video_pkg;

    typedef enum logic [1:0] {
        STAGE_START = 2'd0,
        STAGE_GAME  = 2'd1,
        STAGE_WIN   = 2'd2,
        STAGE_LOSE  = 2'd3
    } stage_t;

    typedef enum logic [1:0] {
        FADE_IDLE = 2'd0,
        FADE_OUT  = 2'd1,
        FADE_IN   = 2'd2
    } fade_state_t;

    // Reference colours are authored at 8 bits per channel.
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t START_RGB    = '{8'hFF, 8'h6D, 8'h00};
    localparam rgb_t WIN_RGB      = '{8'h9C, 8'h1D, 8'h08};
    localparam rgb_t LOSE_RGB     = '{8'h57, 8'h00, 8'h7F};
    localparam rgb_t PLATFORM_RGB = '{8'h00, 8'hFF, 8'h00};

    // Game-stage sky: fixed red, blue ramps down with DrawX/8.
    localparam logic [7:0] SKY_R     = 8'h3F;
    localparam logic [7:0] SKY_B_MAX = 8'h7F;

endpackage

// File: rtl/layered_color_mapper_if.sv
// Pixel-side bus of the colour mapper: pixel/layer inputs, fade control, VGA outputs.
// Latency: n/a (wiring only).
// Backpressure: none; one pixel per clock, always accepted.
interface layered_color_mapper_if #(
    parameter int NUM_LAYERS = 4,
    parameter int COLOR_W    = 8
);
    logic                              frame_start;
    logic [1:0]                        stage_sel;
    logic [9:0]                        DrawX;
    logic [9:0]                        DrawY;
    logic [NUM_LAYERS-1:0]             layer_hit;
    logic [NUM_LAYERS*3*COLOR_W-1:0]   layer_rgb;
    logic [COLOR_W-1:0]                VGA_R;
    logic [COLOR_W-1:0]                VGA_G;
    logic [COLOR_W-1:0]                VGA_B;
    logic                              fading;
    logic [1:0]                        cur_stage;

    // master: pixel source / frame timing side.
    modport master (
        output frame_start, stage_sel, DrawX, DrawY, layer_hit, layer_rgb,
        input  VGA_R, VGA_G, VGA_B, fading, cur_stage
    );

    // slave: the colour mapper itself.
    modport slave (
        input  frame_start, stage_sel, DrawX, DrawY, layer_hit, layer_rgb,
        output VGA_R, VGA_G, VGA_B, fading, cur_stage
    );
endinterface

// File: rtl/fade_ctrl.sv
// Stage-change fade sequencer: dims to black, swaps stage, brightens back up.
// Latency: state changes one clock after the qualifying input; level moves once per frame_start.
// Backpressure: none; stage requests are sampled continuously, never stalled.
// Ports: Clk, Reset (async active-low), frame_start, stage_sel in; cur_stage, level, fading out.
import video_pkg::*;

module fade_ctrl #(
    parameter int FADE_BITS = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             frame_start,
    input  stage_t           stage_sel,
    output stage_t           cur_stage,
    output logic [FADE_BITS:0] level,
    output logic             fading
);

    localparam logic [FADE_BITS:0] LEVEL_ONE = (FADE_BITS+1)'(1);
    localparam logic [FADE_BITS:0] LEVEL_MAX = LEVEL_ONE << FADE_BITS;

    fade_state_t         state, state_nxt;
    stage_t              stage_nxt;
    logic [FADE_BITS:0]  level_nxt;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= FADE_IDLE;
            cur_stage <= STAGE_START;
            level     <= LEVEL_MAX;
        end else begin
            state     <= state_nxt;
            cur_stage <= stage_nxt;
            level     <= level_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        stage_nxt = cur_stage;
        level_nxt = level;
        case (state)
            FADE_IDLE: begin
                if (stage_sel != cur_stage) state_nxt = FADE_OUT;
            end
            FADE_OUT: begin
                // Requests arriving while dimming are absorbed: whatever is
                // on stage_sel at the black frame is what gets shown.
                if (frame_start) begin
                    if (level != '0) begin
                        level_nxt = level - LEVEL_ONE;
                    end else begin
                        stage_nxt = stage_sel;
                        state_nxt = FADE_IN;
                    end
                end
            end
            FADE_IN: begin
                // A new request while brightening turns around at the
                // current level rather than snapping to black.
                if (stage_sel != cur_stage) begin
                    state_nxt = FADE_OUT;
                end else if (frame_start) begin
                    if (level != LEVEL_MAX) level_nxt = level + LEVEL_ONE;
                    else                    state_nxt = FADE_IDLE;
                end
            end
            default: state_nxt = FADE_IDLE;
        endcase
    end

    assign fading = (state != FADE_IDLE);

endmodule

// File: rtl/layered_color_mapper.sv
// Priority-resolves sprite layers over a stage background and applies the fade level.
// Latency: 2 clocks from pixel inputs to VGA_R/G/B (S1 colour select, S2 brightness scale).
// Backpressure: none; one pixel per clock, fade sequencing handled in fade_ctrl.
// Ports: Clk, Reset (async active-low), bus (slave modport: pixel inputs, VGA/fade outputs).
import video_pkg::*;

module layered_color_mapper #(
    parameter int NUM_LAYERS = 4,
    parameter int COLOR_W    = 8,
    parameter int FADE_BITS  = 4,
    parameter int PLATFORM_Y = 380
) (
    input  logic Clk,
    input  logic Reset,
    layered_color_mapper_if.slave bus
);

    localparam int PIX_W  = 3 * COLOR_W;
    localparam int PROD_W = COLOR_W + FADE_BITS + 1;

    stage_t               cur_stage;
    logic [FADE_BITS:0]   level;
    logic                 fading;

    fade_ctrl #(.FADE_BITS(FADE_BITS)) u_fade_ctrl (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_start (bus.frame_start),
        .stage_sel   (stage_t'(bus.stage_sel)),
        .cur_stage   (cur_stage),
        .level       (level),
        .fading      (fading)
    );

    // 8-bit reference channel to COLOR_W, MSB-aligned (zero fill or truncate).
    function automatic logic [COLOR_W-1:0] fit8(input logic [7:0] c);
        return COLOR_W'({c, {COLOR_W{1'b0}}} >> 8);
    endfunction

    function automatic logic [PIX_W-1:0] fit_rgb(input rgb_t c);
        return {fit8(c.r), fit8(c.g), fit8(c.b)};
    endfunction

    function automatic logic [COLOR_W-1:0] scale(input logic [COLOR_W-1:0] c,
                                                 input logic [FADE_BITS:0] lv);
        return COLOR_W'((PROD_W'(c) * PROD_W'(lv)) >> FADE_BITS);
    endfunction

    // S1: base colour select.
    logic [PIX_W-1:0] base_c;
    logic [PIX_W-1:0] s1_rgb;

    always_comb begin
        base_c = fit_rgb(START_RGB);
        case (cur_stage)
            STAGE_WIN:  base_c = fit_rgb(WIN_RGB);
            STAGE_LOSE: base_c = fit_rgb(LOSE_RGB);
            STAGE_GAME: begin
                if (int'(bus.DrawY) >= PLATFORM_Y)
                    base_c = fit_rgb(PLATFORM_RGB);
                else
                    base_c = fit_rgb(rgb_t'{SKY_R, 8'h00, SKY_B_MAX - 8'(bus.DrawX >> 3)});
                // Walk from lowest priority up so the lowest set index is the
                // last writer and therefore wins.
                for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
                    if (bus.layer_hit[i]) base_c = bus.layer_rgb[i*PIX_W +: PIX_W];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) s1_rgb <= '0;
        else        s1_rgb <= base_c;
    end

    // S2: brightness scale using the level current at this stage.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            bus.VGA_R <= '0;
            bus.VGA_G <= '0;
            bus.VGA_B <= '0;
        end else begin
            bus.VGA_R <= scale(s1_rgb[2*COLOR_W +: COLOR_W], level);
            bus.VGA_G <= scale(s1_rgb[COLOR_W   +: COLOR_W], level);
            bus.VGA_B <= scale(s1_rgb[0         +: COLOR_W], level);
        end
    end

    assign bus.fading    = fading;
    assign bus.cur_stage = cur_stage;

endmodule

// File: tb/tb_layered_color_mapper.sv
// Scoreboard bench for layered_color_mapper: random pixels and stage requests against a reference model.
// Latency: expects VGA 2 clocks after inputs, stage/fading 1 clock after inputs.
// Backpressure: n/a.
module tb_layered_color_mapper;

    localparam int NL   = 4;
    localparam int CW   = 8;
    localparam int FB   = 4;
    localparam int PY   = 380;
    localparam int LMAX = 1 << FB;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    layered_color_mapper_if #(.NUM_LAYERS(NL), .COLOR_W(CW)) bus ();

    layered_color_mapper #(
        .NUM_LAYERS (NL),
        .COLOR_W    (CW),
        .FADE_BITS  (FB),
        .PLATFORM_Y (PY)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct {
        int          due;
        logic [23:0] rgb;
        logic [1:0]  st;
        logic        fad;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    // Reference model state: displayed stage, brightness, fade in progress, dimming direction.
    int          m_stage;
    int          m_level;
    bit          m_busy;
    bit          m_dim;
    logic [23:0] base_prev;

    // Current pixel stimulus.
    logic [NL-1:0]    px_hit;
    logic [NL*24-1:0] px_rgb;
    int               px_x;
    int               px_y;

    function automatic logic [23:0] base_ref(input int st, input logic [NL-1:0] hit,
                                             input logic [NL*24-1:0] rgbs, input int x, input int y);
        logic [23:0] c;
        bit          found;
        found = 0;
        c = 24'h0;
        case (st)
            0: c = 24'hFF6D00;
            2: c = 24'h9C1D08;
            3: c = 24'h57007F;
            default: begin
                for (int i = 0; i < NL; i++) begin
                    if (!found && hit[i]) begin
                        c = rgbs[i*24 +: 24];
                        found = 1;
                    end
                end
                if (!found) begin
                    if (y >= PY) c = 24'h00FF00;
                    else         c = {8'h3F, 8'h00, 8'(127 - x / 8)};
                end
            end
        endcase
        return c;
    endfunction

    function automatic logic [23:0] scale_ref(input logic [23:0] c, input int lv);
        return {8'((int'(c[23:16]) * lv) / LMAX),
                8'((int'(c[15:8])  * lv) / LMAX),
                8'((int'(c[7:0])   * lv) / LMAX)};
    endfunction

    task automatic model_advance(input bit fs, input int sel);
        if (!m_busy) begin
            if (sel != m_stage) begin
                m_busy = 1;
                m_dim  = 1;
            end
        end else if (m_dim) begin
            if (fs) begin
                if (m_level > 0) m_level--;
                else begin
                    m_stage = sel;
                    m_dim   = 0;
                end
            end
        end else if (sel != m_stage) begin
            m_dim = 1;
        end else if (fs) begin
            if (m_level < LMAX) m_level++;
            else                m_busy = 0;
        end
    endtask

    task automatic model_reset();
        m_stage   = 0;
        m_level   = LMAX;
        m_busy    = 0;
        m_dim     = 0;
        base_prev = 24'h0;
    endtask

    task automatic rand_pixel();
        px_hit = NL'($urandom);
        if ($urandom_range(0, 2) == 0) px_hit = '0;
        for (int i = 0; i < NL; i++) px_rgb[i*24 +: 24] = 24'($urandom);
        px_x = $urandom_range(0, 639);
        px_y = $urandom_range(0, 479);
    endtask

    // One pixel clock: drive inputs, queue the response they will cause.
    task automatic step(input bit fs, input int sel, input string tag);
        exp_t e;
        @(negedge Clk);
        Reset           = 1'b1;
        bus.frame_start = fs;
        bus.stage_sel   = 2'(sel);
        bus.layer_hit   = px_hit;
        bus.layer_rgb   = px_rgb;
        bus.DrawX       = 10'(px_x);
        bus.DrawY       = 10'(px_y);
        e.due = cyc + 1;
        e.rgb = scale_ref(base_prev, m_level);
        base_prev = base_ref(m_stage, px_hit, px_rgb, px_x, px_y);
        model_advance(fs, sel);
        e.st  = 2'(m_stage);
        e.fad = m_busy;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic frames(input int n, input int sel, input string tag);
        for (int i = 0; i < n; i++) begin
            step(1'b1, sel, tag);
            step(1'b0, sel, tag);
        end
    endtask

    task automatic settle(input int sel, input string tag);
        int guard;
        guard = 0;
        step(1'b0, sel, tag);
        while (m_busy && guard < 100) begin
            frames(1, sel, tag);
            guard++;
        end
        if (m_busy) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: fade still busy after %0d frames, required idle", tag, guard);
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        #2;
        sb.delete();
        Reset = 1'b0;
        bus.frame_start = 1'b0;
        bus.stage_sel   = 2'd0;
        model_reset();
        #1;
        vectors++;
        if ({bus.VGA_R, bus.VGA_G, bus.VGA_B} !== 24'h0 || bus.fading !== 1'b0 || bus.cur_stage !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_clear: rgb=%h fading=%b stage=%0d, required 000000/0/0",
                     {bus.VGA_R, bus.VGA_G, bus.VGA_B}, bus.fading, bus.cur_stage);
        end
        repeat (3) @(posedge Clk);
    endtask

    // Monitor: every cycle with a due expectation, compare all outputs.
    always @(negedge Clk) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
            exp_t e;
            e = sb.pop_front();
            vectors++;
            if ({bus.VGA_R, bus.VGA_G, bus.VGA_B} !== e.rgb || bus.cur_stage !== e.st || bus.fading !== e.fad) begin
                miscompares++;
                $display("FAIL %s @cyc %0d: rgb=%h stage=%0d fading=%b, required rgb=%h stage=%0d fading=%b",
                         e.tag, cyc, {bus.VGA_R, bus.VGA_G, bus.VGA_B}, bus.cur_stage, bus.fading,
                         e.rgb, e.st, e.fad);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int sel;
        int guard;
        bus.frame_start = 1'b0;
        bus.stage_sel   = 2'd0;
        bus.layer_hit   = '0;
        bus.layer_rgb   = '0;
        bus.DrawX       = '0;
        bus.DrawY       = '0;
        px_hit = '0;
        px_rgb = '0;
        px_x   = 0;
        px_y   = 0;
        model_reset();

        // Reset, then start screen at full brightness.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            rand_pixel();
            step(1'b0, 0, "start_screen");
        end
        frames(2, 0, "idle_frame_no_effect");

        // Into the game stage.
        settle(1, "fade_to_game");

        // Directed game pixels.
        px_rgb = '0;
        px_rgb[1*24 +: 24] = 24'h112233;
        px_rgb[2*24 +: 24] = 24'hAABBCC;
        px_hit = 4'b0110; px_x = 5;  px_y = 420; step(1'b0, 1, "layer_priority");
        px_hit = 4'b1100; px_x = 5;  px_y = 420; step(1'b0, 1, "layer_priority2");
        px_hit = 4'b0000; px_x = 0;  px_y = 380; step(1'b0, 1, "platform_edge");
        px_hit = 4'b0000; px_x = 0;  px_y = 379; step(1'b0, 1, "sky_edge");
        px_hit = 4'b0000; px_x = 80; px_y = 100; step(1'b0, 1, "sky_ramp");
        px_hit = 4'b0000; px_x = 639; px_y = 0;  step(1'b0, 1, "sky_ramp_max");

        // Game -> win with a platform pixel held steady.
        px_hit = '0; px_x = 10; px_y = 400;
        settle(2, "fade_game_to_win");
        frames(2, 2, "win_settled");

        // Turn around during fade-in at level 8.
        step(1'b0, 1, "fade_to_game2");
        guard = 0;
        while (!(m_busy && !m_dim && m_level == 8) && guard < 100) begin
            frames(1, 1, "fade_to_game2");
            guard++;
        end
        settle(3, "fadein_turnaround");

        // Request change back to displayed stage mid fade-out: no abort.
        step(1'b0, 2, "no_abort");
        frames(3, 2, "no_abort");
        settle(3, "no_abort");

        // Reset in the middle of a fade-out.
        step(1'b0, 2, "fade_before_reset");
        guard = 0;
        while (!(m_dim && m_level == 5) && guard < 100) begin
            frames(1, 2, "fade_before_reset");
            guard++;
        end
        do_reset();
        for (int i = 0; i < 4; i++) begin
            rand_pixel();
            step(1'b0, 0, "after_mid_reset");
        end

        // Random traffic: sparse frame pulses, occasional stage requests.
        sel = 0;
        for (int i = 0; i < 3000; i++) begin
            rand_pixel();
            if ($urandom_range(0, 63) == 0) sel = $urandom_range(0, 3);
            step($urandom_range(0, 5) == 0, sel, "random");
        end

        for (int i = 0; i < 3; i++) step(1'b0, sel, "drain");
        @(negedge Clk);
        #1;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
